// File: rtl/add_sub_pkg.sv
// Shared datapath width and op-code encodings for the add-class execute stage.
package add_sub_pkg;
`ifdef RV32GC_ISA
  localparam int XLEN_DEF = 32;
`else
  localparam int XLEN_DEF = 64;
`endif
  localparam int OPW_DEF = 3;

  localparam logic [OPW_DEF-1:0] OP_ADD  = 3'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB  = 3'd1;
  localparam logic [OPW_DEF-1:0] OP_ADDW = 3'd2;
  localparam logic [OPW_DEF-1:0] OP_SUBW = 3'd3;
  localparam logic [OPW_DEF-1:0] OP_SLT  = 3'd4;
  localparam logic [OPW_DEF-1:0] OP_SLTU = 3'd5;
endpackage

// File: rtl/CLA_64_32.sv
// Three-level carry-lookahead adder: 4-bit groups, 16-bit blocks, block chain.
// Builds as 64-bit (4 blocks) or 32-bit (2 blocks) from XLEN.
module CLA_64_32 #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Ci,
  output logic [XLEN-1:0] S,
  output logic            Co,
  output logic            Gm,
  output logic            Pm
);
  localparam int NG = XLEN / 4;
  localparam int NB = NG / 4;

  logic [XLEN-1:0] g_s, p_s, c_s;
  logic [NG-1:0]   gg_s, gp_s, gc_s;
  logic [NB-1:0]   bg_s, bp_s, bc_s;

  assign g_s = A & B;
  assign p_s = A ^ B;
  assign S   = p_s ^ c_s;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    assign gg_s[k] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                   | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                   | (&p_s[4*k+1 +: 3] & g_s[4*k]);
    assign gp_s[k] = &p_s[4*k +: 4];
  end

  for (genvar j = 0; j < NB; j++) begin : g_blk
    assign bg_s[j] = gg_s[4*j+3] | (gp_s[4*j+3] & gg_s[4*j+2])
                   | (gp_s[4*j+3] & gp_s[4*j+2] & gg_s[4*j+1])
                   | (&gp_s[4*j+1 +: 3] & gg_s[4*j]);
    assign bp_s[j] = &gp_s[4*j +: 4];
  end

  // Top level: carry into each block plus whole-word generate/propagate
  always_comb begin
    logic cb, gm, pm;
    cb   = Ci;
    gm   = 1'b0;
    pm   = 1'b1;
    bc_s = {NB{1'b0}};
    for (int j = 0; j < NB; j++) begin
      bc_s[j] = cb;
      cb      = bg_s[j] | (bp_s[j] & cb);
      gm      = bg_s[j] | (bp_s[j] & gm);
      pm      = pm & bp_s[j];
    end
    Co = cb;
    Gm = gm;
    Pm = pm;
  end

  // Middle level: carry into each 4-bit group from its block carry
  always_comb begin
    logic cg;
    cg   = 1'b0;
    gc_s = {NG{1'b0}};
    for (int k = 0; k < NG; k++) begin
      cg = bc_s[k/4];
      for (int t = (k/4)*4; t < k; t++) cg = gg_s[t] | (gp_s[t] & cg);
      gc_s[k] = cg;
    end
  end

  // Bottom level: carry into each bit from its group carry
  always_comb begin
    logic cin;
    cin = 1'b0;
    c_s = {XLEN{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      cin = gc_s[i/4];
      for (int t = (i/4)*4; t < i; t++) cin = g_s[t] | (p_s[t] & cin);
      c_s[i] = cin;
    end
  end
endmodule

// File: rtl/add_sub_exec_stage.sv
// Two-stage add-class execute pipeline: operand prep register, then CLA add
// and result/flag formatting register, with valid/ready on both sides and flush.
module add_sub_exec_stage
  import add_sub_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd,
  output logic            out_carry,
  output logic            out_overflow
);
  localparam bit W_OK  = (XLEN == 64);
  localparam int W_IDX = (XLEN > 32) ? 32 : 0;

  logic            s1_valid_r, s2_valid_r, ci_r, carry_r, ovf_r;
  logic [XLEN-1:0] a_r, b_r, result_r, b_prep_s, sum_s, res_s;
  logic [OPW-1:0]  op_r;
  logic [4:0]      rd_r, out_rd_r;
  logic            ci_prep_s, co_s, carry_s, ovf_s, ovf_full_s, ovf_w_s;
  logic            s1_adv_s, s2_adv_s, in_ready_s, gm_unused_s, pm_unused_s;

  assign s2_adv_s   = !s2_valid_r || out_ready;
  assign s1_adv_s   = s1_valid_r && s2_adv_s;
  assign in_ready_s = !flush && (!s1_valid_r || s2_adv_s);

  assign in_ready     = in_ready_s;
  assign out_valid    = s2_valid_r;
  assign out_result   = result_r;
  assign out_rd       = out_rd_r;
  assign out_carry    = carry_r;
  assign out_overflow = ovf_r;

  // Subtract-style ops add the inverted B with a carry-in of one
  always_comb begin
    case (in_op)
      OP_SUB, OP_SUBW, OP_SLT, OP_SLTU: begin
        b_prep_s  = ~in_b;
        ci_prep_s = 1'b1;
      end
      default: begin
        b_prep_s  = in_b;
        ci_prep_s = 1'b0;
      end
    endcase
  end

  // Stage 1: valid and prepared operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      a_r        <= {XLEN{1'b0}};
      b_r        <= {XLEN{1'b0}};
      ci_r       <= 1'b0;
      op_r       <= {OPW{1'b0}};
      rd_r       <= 5'd0;
    end else begin
      if (flush) s1_valid_r <= 1'b0;
      else if (in_ready_s) s1_valid_r <= in_valid;
      if (in_valid && in_ready_s) begin
        a_r  <= in_a;
        b_r  <= b_prep_s;
        ci_r <= ci_prep_s;
        op_r <= in_op;
        rd_r <= in_rd;
      end
    end
  end

  CLA_64_32 #(.XLEN(XLEN)) u_cla (
    .A  (a_r),
    .B  (b_r),
    .Ci (ci_r),
    .S  (sum_s),
    .Co (co_s),
    .Gm (gm_unused_s),
    .Pm (pm_unused_s)
  );

  // b_r already holds B', so the same overflow test serves add and subtract
  assign ovf_full_s = (a_r[XLEN-1] == b_r[XLEN-1]) && (sum_s[XLEN-1] != a_r[XLEN-1]);
  assign ovf_w_s    = (a_r[31] == b_r[31]) && (sum_s[31] != a_r[31]);

  // Stage 2 result and flag formatting per op
  always_comb begin
    res_s   = {XLEN{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_r)
      OP_ADD, OP_SUB: begin
        res_s   = sum_s;
        carry_s = co_s;
        ovf_s   = ovf_full_s;
      end
      OP_ADDW, OP_SUBW: begin
        if (W_OK) begin
          res_s = sum_s;
          for (int i = 32; i < XLEN; i++) res_s[i] = sum_s[31];
          carry_s = sum_s[W_IDX] ^ a_r[W_IDX] ^ b_r[W_IDX];
          ovf_s   = ovf_w_s;
        end else begin
          res_s   = {XLEN{1'b0}};
          carry_s = 1'b0;
          ovf_s   = 1'b0;
        end
      end
      OP_SLT: begin
        res_s[0] = sum_s[XLEN-1] ^ ovf_full_s;
        carry_s  = co_s;
      end
      OP_SLTU: begin
        res_s[0] = ~co_s;
        carry_s  = co_s;
      end
      default: begin
        res_s   = {XLEN{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
  end

  // Stage 2: output valid and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= {XLEN{1'b0}};
      out_rd_r   <= 5'd0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      if (flush) s2_valid_r <= 1'b0;
      else if (s2_adv_s) s2_valid_r <= s1_valid_r;
      if (s1_adv_s && !flush) begin
        result_r <= res_s;
        out_rd_r <= rd_r;
        carry_r  <= carry_s;
        ovf_r    <= ovf_s;
      end
    end
  end
endmodule

// File: tb/tb_add_sub_exec_stage.sv
// Scoreboard bench for add_sub_exec_stage: arithmetic reference model, queue of
// expected responses, and an independent output monitor.
module tb_add_sub_exec_stage;
  import add_sub_pkg::*;

  typedef struct packed {
    logic [63:0] result;
    logic [4:0]  rd;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic        out_carry, out_overflow;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   rand_done;
  logic [63:0] snap_res;
  logic [4:0]  snap_rd;
  logic        snap_c, snap_o;

  add_sub_exec_stage #(.XLEN(64), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_carry(out_carry), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Reference model: plain two's-complement arithmetic on the op definitions
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] rd);
    exp_t e;
    logic [64:0] w;
    logic [32:0] h;
    logic [31:0] r32;
    e.rd = rd; e.result = 64'd0; e.carry = 1'b0; e.ovf = 1'b0;
    case (op)
      3'd0: begin
        w = {1'b0, a} + {1'b0, b};
        e.result = w[63:0]; e.carry = w[64];
        e.ovf = (a[63] == b[63]) && (w[63] != a[63]);
      end
      3'd1: begin
        e.result = a - b; e.carry = (a >= b);
        e.ovf = (a[63] != b[63]) && (e.result[63] != a[63]);
      end
      3'd2: begin
        h = {1'b0, a[31:0]} + {1'b0, b[31:0]};
        e.result = {{32{h[31]}}, h[31:0]}; e.carry = h[32];
        e.ovf = (a[31] == b[31]) && (h[31] != a[31]);
      end
      3'd3: begin
        r32 = a[31:0] - b[31:0];
        e.result = {{32{r32[31]}}, r32}; e.carry = (a[31:0] >= b[31:0]);
        e.ovf = (a[31] != b[31]) && (r32[31] != a[31]);
      end
      3'd4: begin
        e.result = {63'd0, ($signed(a) < $signed(b))}; e.carry = (a >= b);
      end
      3'd5: begin
        e.result = {63'd0, (a < b)}; e.carry = (a >= b);
      end
      default: begin
        e.result = 64'd0; e.carry = 1'b0; e.ovf = 1'b0;
      end
    endcase
    return e;
  endfunction

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return {32'h0, $urandom()};
      5: return {$urandom(), 32'h7FFF_FFFF};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Present one op; called just after a rising edge, returns just after its acceptance edge
  task automatic send(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [4:0] rd);
    int waited = 0;
    bit done = 1'b0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(op, a, b, rd));
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          n_checks++; n_fail++;
          $display("FAIL send_timeout: in_ready low for %0d cycles, expected acceptance", waited);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check64("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every downstream transfer is checked against the scoreboard head
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_output: got rd %0d result 0x%0h, expected no output", out_rd, out_result);
      end else begin
        mon_e = exp_q.pop_front();
        check64("result", out_result, mon_e.result);
        check64("rd", 64'(out_rd), 64'(mon_e.rd));
        check1("carry", out_carry, mon_e.carry);
        check1("overflow", out_overflow, mon_e.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_before;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
    in_a = 64'd0; in_b = 64'd0; in_rd = 5'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("reset_out_valid", out_valid, 1'b0);
    check64("reset_result", out_result, 64'd0);
    check64("reset_rd", 64'(out_rd), 64'd0);
    check1("reset_carry", out_carry, 1'b0);
    check1("reset_overflow", out_overflow, 1'b0);
    check1("reset_in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and directed corner values
    out_ready = 1'b1;
    send(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'd1);
    check1("latency_one_edge", out_valid, 1'b0);
    @(posedge clk); #1;
    check1("latency_two_edges", out_valid, 1'b1);
    send(OP_SUB, 64'd5, 64'd7, 5'd2);
    send(OP_SLTU, 64'd5, 64'd7, 5'd3);
    send(OP_SLT, {64{1'b1}}, 64'd1, 5'd4);
    send(OP_ADDW, 64'h0000_0001_7FFF_FFFF, 64'd1, 5'd5);
    send(OP_SUBW, 64'd0, 64'd0, 5'd6);
    send(OP_SLT, 64'h8000_0000_0000_0000, 64'd1, 5'd7);
    send(OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 5'd8);
    drain();

    // Back-to-back ops with a downstream stall after the first result
    out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 64'd10, 64'd20, 5'd10);
        send(OP_SUB, 64'd3, 64'd9, 5'd11);
        send(OP_SLT, 64'd4, {64{1'b1}}, 5'd12);
        send(OP_SLTU, 64'd4, {64{1'b1}}, 5'd13);
      end
      begin
        int t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        check1("stall_first_valid", out_valid, 1'b1);
        snap_res = out_result; snap_rd = out_rd; snap_c = out_carry; snap_o = out_overflow;
        check1("stall_in_ready_full", in_ready, 1'b0);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check1("stall_valid_hold", out_valid, 1'b1);
          check64("stall_result_hold", out_result, snap_res);
          check64("stall_rd_hold", 64'(out_rd), 64'(snap_rd));
          check1("stall_carry_hold", out_carry, snap_c);
          check1("stall_ovf_hold", out_overflow, snap_o);
          check1("stall_in_ready", in_ready, 1'b0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush a full pipeline while upstream is offering an op
    out_ready = 1'b0;
    send(OP_ADD, 64'd1, 64'd2, 5'd20);
    send(OP_SUB, 64'd3, 64'd4, 5'd21);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 64'd9; in_b = 64'd9; in_rd = 5'd22;
    flush = 1'b1;
    #1;
    check1("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check1("flush_out_valid", out_valid, 1'b0);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check1("flush_no_stale", out_valid, 1'b0);

    // Flush coinciding with a downstream transfer: that transfer still completes
    out_ready = 1'b0;
    send(OP_ADDW, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 5'd23);
    send(OP_SLTU, 64'd1, 64'd0, 5'd24);
    n_before = n_out;
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check64("flush_xfer_count", 64'(n_out), 64'(n_before + 1));
    check1("flush_xfer_valid", out_valid, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset while a result is waiting
    out_ready = 1'b0;
    send(OP_ADD, 64'd100, 64'd200, 5'd30);
    @(posedge clk); #1;
    check1("pre_reset_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check1("async_reset_valid", out_valid, 1'b0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check1("post_reset_in_ready", in_ready, 1'b1);
    check1("post_reset_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    send(3'd6, 64'hDEAD_BEEF_0000_0001, 64'h1, 5'd31);
    drain();

    // Randomized traffic with random downstream backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
          end
          send(3'($urandom_range(0, 7)), rand_opnd(), rand_opnd(), 5'($urandom_range(0, 31)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
